// File: rtl/screen_pattern_if.sv
// Framebuffer write port carried between screen_pattern and the framebuffer.
// The address width macro lives here so every user of the port agrees on it.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 19
`endif

interface screen_pattern_if;
    logic                        fb_we;
    logic [`DISP_ADDR_WIDTH-1:0] fb_addr;
    logic [31:0]                 fb_wdata;

    modport master (output fb_we, output fb_addr, output fb_wdata);
    modport slave  (input  fb_we, input  fb_addr, input  fb_wdata);
endinterface

// File: rtl/screen_pattern.sv
// Full-screen pattern painter: fills the framebuffer once with a two-colour
// pattern, then holds until a fresh exit-key press after a minimum display time.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 19
`endif

module screen_pattern #(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter logic [11:0] COLOUR_A    = 12'h0F0,
    parameter logic [11:0] COLOUR_B    = 12'h000,
    parameter int unsigned BAR_SIZE    = 32,
    parameter int unsigned HOLD_CYCLES = 25_000_000,
    parameter logic [25:0] KEY_MASK    = 26'h3FF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic                redraw,
    input  logic [25:0]         key_status,
    screen_pattern_if.master    fb,
    output logic                screen_done
);

    localparam int AW = `DISP_ADDR_WIDTH;
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int BW = (BAR_SIZE > 1) ? $clog2(BAR_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_SIZE - 1);

    typedef enum logic [2:0] {S_FILL, S_HOLD, S_ARM, S_WAIT_KEY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [BW-1:0]   xc_q, xc_d, yc_q, yc_d;
    logic            xb_q, xb_d, yb_q, yb_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     hold_q, hold_d;
    logic [1:0]      mode_q, mode_d;
    logic            relatch_q, relatch_d;
    logic            we_q, we_d;
    logic [AW-1:0]   fb_addr_q, fb_addr_d;
    logic [11:0]     wdata_q, wdata_d;
    logic            done_q, done_d;

    logic [1:0]      eff_mode;
    logic [11:0]     pix_colour;
    logic            key_hit;

    always_comb begin
        // The first FILL cycle after reset or redraw uses the live mode input.
        eff_mode = relatch_q ? mode : mode_q;
        key_hit  = |(key_status & KEY_MASK);
        case (eff_mode)
            2'd0:    pix_colour = COLOUR_A;
            2'd1:    pix_colour = yb_q ? COLOUR_B : COLOUR_A;
            2'd2:    pix_colour = xb_q ? COLOUR_B : COLOUR_A;
            default: pix_colour = (xb_q ^ yb_q) ? COLOUR_B : COLOUR_A;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        xc_d      = xc_q;
        yc_d      = yc_q;
        xb_d      = xb_q;
        yb_d      = yb_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        mode_d    = mode_q;
        relatch_d = relatch_q;
        we_d      = 1'b0;
        fb_addr_d = fb_addr_q;
        wdata_d   = wdata_q;
        done_d    = done_q;

        case (state_q)
            S_FILL: begin
                relatch_d = 1'b0;
                mode_d    = eff_mode;
                we_d      = 1'b1;
                fb_addr_d = addr_q;
                wdata_d   = pix_colour;
                addr_d    = addr_q + AW'(1);
                if (x_q == X_LAST) begin
                    x_d  = '0;
                    xc_d = '0;
                    xb_d = 1'b0;
                    if (y_q == Y_LAST) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                    end else begin
                        y_d = y_q + YW'(1);
                        if (yc_q == BAR_LAST) begin
                            yc_d = '0;
                            yb_d = ~yb_q;
                        end else begin
                            yc_d = yc_q + BW'(1);
                        end
                    end
                end else begin
                    x_d = x_q + XW'(1);
                    if (xc_q == BAR_LAST) begin
                        xc_d = '0;
                        xb_d = ~xb_q;
                    end else begin
                        xc_d = xc_q + BW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == 32'(HOLD_CYCLES)) state_d = S_ARM;
                else                             hold_d  = hold_q + 32'd1;
            end
            S_ARM: begin
                if (!key_hit) state_d = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                if (key_hit) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase

        // Redraw outranks a simultaneous key press; a fill in progress always completes.
        if (redraw && state_q != S_FILL) begin
            state_d   = S_FILL;
            done_d    = 1'b0;
            x_d       = '0;
            y_d       = '0;
            xc_d      = '0;
            yc_d      = '0;
            xb_d      = 1'b0;
            yb_d      = 1'b0;
            addr_d    = '0;
            hold_d    = '0;
            relatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FILL;
            x_q       <= '0;
            y_q       <= '0;
            xc_q      <= '0;
            yc_q      <= '0;
            xb_q      <= 1'b0;
            yb_q      <= 1'b0;
            addr_q    <= '0;
            hold_q    <= '0;
            mode_q    <= '0;
            relatch_q <= 1'b1;
            we_q      <= 1'b0;
            fb_addr_q <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            xc_q      <= xc_d;
            yc_q      <= yc_d;
            xb_q      <= xb_d;
            yb_q      <= yb_d;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            mode_q    <= mode_d;
            relatch_q <= relatch_d;
            we_q      <= we_d;
            fb_addr_q <= fb_addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
        end
    end

    assign fb.fb_we     = we_q;
    assign fb.fb_addr   = fb_addr_q;
    assign fb.fb_wdata  = {20'b0, wdata_q};
    assign screen_done  = done_q;

endmodule

// File: doc/screen_pattern.md
Name: screen_pattern

Overview:
- Parametrised successor to the fixed-colour full-screen blocks (solid win/lose screens).
- Fills the framebuffer once with one of four patterns: solid, horizontal bars, vertical bars or checkerboard, using two configurable colours.
- Then holds the screen. It asserts screen_done on a fresh press of any key in a configurable mask, after a minimum display time.
- Sits between the top-level screen sequencer and the framebuffer write port. It is the same drop-in position as the solid screens.

Parameters:
- H_RES, 640, pixels per row.
- V_RES, 480, rows. H_RES*V_RES must fit in `DISP_ADDR_WIDTH.
- COLOUR_A, 12'h0F0, primary 12-bit RGB colour.
- COLOUR_B, 12'h000, secondary 12-bit RGB colour. Unused in solid mode.
- BAR_SIZE, 32, bar width or height and checker cell size, in pixels. Must be 1 or more.
- HOLD_CYCLES, 25_000_000, minimum clk cycles between fill completion and key acceptance. 0 is allowed.
- KEY_MASK, 26'h3FF_FFFF, the key_status bits that count as exit keys.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset. All state is cleared immediately.
- mode  input  2  pattern select: 0 solid, 1 horizontal bars, 2 vertical bars, 3 checkerboard. Sampled on entry to FILL.
- redraw  input  1  single-cycle request to repaint and re-arm. Honoured in HOLD, ARM, WAIT_KEY and DONE.
- key_status  input  26  level key state, 1 = pressed.
- fb_we  output  1  framebuffer write enable.
- fb_addr  output  `DISP_ADDR_WIDTH  linear pixel address, y*H_RES+x.
- fb_wdata  output  32  {20'b0, colour[11:0]}.
- screen_done  output  1  level. High from exit-key acceptance until reset or redraw.

Behaviour:
- Reset values: state=FILL, x=0, y=0, hold counter=0, fb_we=0, fb_addr=0, fb_wdata=0, screen_done=0.
- On reset release, mode is latched and FILL begins on the first clk edge.
- FILL: one pixel per cycle. fb_we, fb_addr and fb_wdata are registered and change together.
  - The write for pixel (x,y) appears one cycle after it is computed.
  - Exactly H_RES*V_RES consecutive cycles have fb_we=1, with addresses 0 to H_RES*V_RES-1 in order. There are no gaps and no repeats.
- Colour selection uses bar phase counters, never dividers.
  - xb toggles each time x crosses a BAR_SIZE boundary. It resets to 0 at x=0.
  - yb toggles the same way on y.
  - solid: A. hbar: yb ? B : A. vbar: xb ? B : A. checker: (xb^yb) ? B : A.
  - A partial last bar is allowed, e.g. H_RES not a multiple of BAR_SIZE.
- Address counter: increments by 1 each write.
  - x wraps at H_RES-1 to 0 and y increments.
  - After the write of (H_RES-1, V_RES-1), go to HOLD. fb_we is 0 from the next cycle on.
- HOLD: the counter counts HOLD_CYCLES cycles, then goes to ARM. With HOLD_CYCLES=0, go to ARM on the next cycle. key_status is ignored.
- ARM: wait until (key_status & KEY_MASK)==0, then go to WAIT_KEY. This stops a key held from the previous screen from exiting instantly.
- WAIT_KEY: on the first cycle where (key_status & KEY_MASK)!=0, go to DONE. screen_done=1 from the next cycle.
- DONE: screen_done stays 1 and there are no writes. The block stays here until reset or redraw.
- redraw behaviour:
  - In HOLD, ARM, WAIT_KEY or DONE: screen_done=0 next cycle, counters clear, mode is re-latched and FILL restarts at address 0.
  - During FILL, redraw is ignored. The fill always completes.
- mode changes during FILL have no effect on the current fill.
- Reset mid-FILL: outputs go to their reset values asynchronously, and the fill restarts from address 0 after release.
- Key press and redraw in the same cycle in WAIT_KEY: redraw wins. Go to FILL with screen_done=0.
- Unused high bits of fb_addr are 0. fb_wdata[31:12] is always 0.

Test Plan:
- H_RES=8, V_RES=4, mode=0, COLOUR_A=12'h0F0, HOLD_CYCLES=0 -> exactly 32 fb_we cycles, addr 0..31 in order, every wdata=32'h0000_00F0, then fb_we=0.
- mode=3, BAR_SIZE=2, A=12'hFFF, B=12'h000, same geometry:
  - addr 0,1 -> FFF; addr 2,3 -> 000.
  - addr 8 (x=0,y=1) -> FFF; addr 16 (y=2) -> 000.
- HOLD_CYCLES=10, key_status bit 3 held from reset -> no screen_done while held. Release, then press bit 3 -> screen_done=1 one cycle after the press, and it stays high.
- KEY_MASK=26'h000_0001: press bit 5 in WAIT_KEY -> screen_done stays 0. Press bit 0 -> screen_done=1.
- In DONE, pulse redraw with mode=1 -> screen_done=0 next cycle, 32-pixel fill restarts at addr 0 with hbar colours (rows 0,1 A; rows 2,3 B for BAR_SIZE=2).
- Assert reset at fill pixel 13 -> fb_we=0 and screen_done=0 immediately. After release, writes restart at addr 0 and all 32 pixels are written.
